// File: rtl/avalon_sram_ctrl_pkg.sv
// Shared types and elaboration helpers for the Avalon-MM to async SRAM bridge.
package avalon_sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACC,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit params_ok(input int dw, input int rw, input int wp);
        return (dw > 0) && (dw % 8 == 0) && (rw >= 1) && (wp >= 1);
    endfunction

endpackage

// File: rtl/avalon_sram_ctrl_if.sv
// Avalon-MM request/response bundle between the Nios interconnect and the bridge.
interface avalon_sram_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
) ();
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, byteenable, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing each SRAM access phase; stops at 1.
module sram_wait_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q > CNT_W'(1))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero load (unused phase) reads as done rather than wrapping.
    assign done_o = (cnt_q <= CNT_W'(1));
endmodule

// File: rtl/avalon_sram_ctrl.sv
// Avalon-MM slave to asynchronous SRAM controller with programmable strobe timing.
module avalon_sram_ctrl
    import avalon_sram_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 16,
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2,
    parameter int WR_HOLD  = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_sram_ctrl_if.slave   avs,
    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_data,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic [BE_W-1:0]     sram_be_n
);
    localparam int CNT_W = $clog2(max3(RD_WAIT, WR_PULSE, WR_HOLD) + 1);
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WP_CNT = CNT_W'(WR_PULSE);
    localparam logic [CNT_W-1:0] WH_CNT = CNT_W'(WR_HOLD);

    if (!params_ok(DATA_W, RD_WAIT, WR_PULSE)) begin : g_bad_params
        $error("avalon_sram_ctrl: illegal DATA_W/RD_WAIT/WR_PULSE");
    end

    state_e             state_q, state_d;
    logic               cnt_load, cnt_en, cnt_done;
    logic [CNT_W-1:0]   cnt_val;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [BE_W-1:0]    be_n_q, be_n_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               drv_q, drv_d;
    logic               active;

    sram_wait_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (reset_n),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .val_i  (cnt_val),
        .done_o (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = RD_CNT;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (avs.write || avs.read) begin
                    addr_d   = avs.address;
                    be_d     = avs.byteenable;
                    wdata_d  = avs.writedata;
                    cnt_load = 1'b1;
                    if (avs.write) begin
                        state_d = S_WR_PULSE;
                        cnt_val = WP_CNT;
                    end else begin
                        state_d = S_RD_ACC;
                    end
                end
            end
            S_RD_ACC: begin
                if (cnt_done) begin
                    rdata_d = sram_data;
                    state_d = S_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_WR_PULSE: begin
                if (!cnt_done) begin
                    cnt_en = 1'b1;
                end else if (WR_HOLD == 0) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_WR_HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = WH_CNT;
                end
            end
            S_WR_HOLD: begin
                if (cnt_done) begin
                    state_d = S_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin registers are computed from the next state so strobes align with it.
    always_comb begin
        active = (state_d == S_RD_ACC) || (state_d == S_WR_PULSE) ||
                 (state_d == S_WR_HOLD);
        ce_n_d = !active;
        oe_n_d = (state_d != S_RD_ACC);
        we_n_d = (state_d != S_WR_PULSE);
        drv_d  = (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
        be_n_d = active ? ~be_d : '1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            be_n_q  <= '1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            be_n_q  <= be_n_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            drv_q   <= drv_d;
        end
    end

    assign sram_data       = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr       = addr_q;
    assign sram_ce_n       = ce_n_q;
    assign sram_oe_n       = oe_n_q;
    assign sram_we_n       = we_n_q;
    assign sram_be_n       = be_n_q;
    assign avs.readdata    = rdata_q;
    assign avs.waitrequest = (state_q != S_DONE);
endmodule

// File: tb/tb_avalon_sram_ctrl.sv
// Randomized self-checking bench: two bridge configurations against pin-level SRAM models.
module tb_avalon_sram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    avalon_sram_ctrl_if #(.ADDR_W(19), .DATA_W(16)) busA ();
    avalon_sram_ctrl_if #(.ADDR_W(19), .DATA_W(32)) busB ();

    logic [18:0] addrA, addrB;
    wire  [15:0] dataA;
    wire  [31:0] dataB;
    logic        ceA, oeA, weA, ceB, oeB, weB;
    logic [1:0]  beA;
    logic [3:0]  beB;

    avalon_sram_ctrl #(.ADDR_W(19), .DATA_W(16), .RD_WAIT(2),
                       .WR_PULSE(2), .WR_HOLD(1)) dutA (
        .clk(clk), .reset_n(rst_n), .avs(busA.slave),
        .sram_addr(addrA), .sram_data(dataA), .sram_ce_n(ceA),
        .sram_oe_n(oeA), .sram_we_n(weA), .sram_be_n(beA)
    );

    avalon_sram_ctrl #(.ADDR_W(19), .DATA_W(32), .RD_WAIT(1),
                       .WR_PULSE(1), .WR_HOLD(0)) dutB (
        .clk(clk), .reset_n(rst_n), .avs(busB.slave),
        .sram_addr(addrB), .sram_data(dataB), .sram_ce_n(ceB),
        .sram_oe_n(oeB), .sram_we_n(weB), .sram_be_n(beB)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    // Pin-level SRAM models: drive on CE&OE low, write lanes while CE&WE low.
    logic [15:0] memA [logic [18:0]];
    logic [31:0] memB [logic [18:0]];
    logic [15:0] drvA = '0;
    logic [31:0] drvB = '0;

    always @(posedge clk) begin
        #2;
        drvA <= memA.exists(addrA) ? memA[addrA] : 16'h0;
        drvB <= memB.exists(addrB) ? memB[addrB] : 32'h0;
    end

    always @(posedge clk) begin
        if (!ceA && !weA)
            memA[addrA] = 16'(merge({16'h0, memA.exists(addrA) ? memA[addrA] : 16'h0},
                                    {16'h0, dataA}, {2'b00, ~beA}));
        if (!ceB && !weB)
            memB[addrB] = merge(memB.exists(addrB) ? memB[addrB] : 32'h0,
                                dataB, ~beB);
    end

    assign dataA = (!ceA && !oeA) ? drvA : 16'hzzzz;
    assign dataB = (!ceB && !oeB) ? drvB : 32'hzzzz_zzzz;

    // Transaction-level reference: word store keyed by {config, address}.
    logic [31:0] refm [logic [19:0]];
    logic [31:0] last_rd [2];

    function automatic logic [31:0] ref_get(input logic [19:0] k);
        return refm.exists(k) ? refm[k] : 32'h0;
    endfunction

    logic prevA = 1'b1;
    logic prevB = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!oeA) begin
                chk("A_oe_we_excl", {31'h0, weA}, 32'h1);
                chk("A_rd_bus", {16'h0, dataA}, {16'h0, drvA});
            end
            if (!oeB) begin
                chk("B_oe_we_excl", {31'h0, weB}, 32'h1);
                chk("B_rd_bus", dataB, drvB);
            end
            if (!busA.waitrequest) chk("A_done_1cyc", {31'h0, prevA}, 32'h1);
            if (!busB.waitrequest) chk("B_done_1cyc", {31'h0, prevB}, 32'h1);
        end
        prevA <= busA.waitrequest;
        prevB <= busB.waitrequest;
    end

    int cur = 0;
    wire        m_oe   = (cur != 0) ? oeB : oeA;
    wire        m_we   = (cur != 0) ? weB : weA;
    wire        m_wait = (cur != 0) ? busB.waitrequest : busA.waitrequest;
    wire [3:0]  m_be_n = (cur != 0) ? beB : {2'b11, beA};
    wire [31:0] m_rd   = (cur != 0) ? busB.readdata : {16'h0, busA.readdata};

    int oe_cnt, oe_first, we_cnt, we_first;
    logic [3:0] be_seen;

    task automatic drive(input int sel, input bit wr, input bit rd,
                         input logic [18:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
        if (sel == 0) begin
            busA.address = a; busA.byteenable = be[1:0];
            busA.writedata = wd[15:0]; busA.write = wr; busA.read = rd;
        end else begin
            busB.address = a; busB.byteenable = be;
            busB.writedata = wd; busB.write = wr; busB.read = rd;
        end
    endtask

    // Starts just after a rising edge; returns just after the edge ending DONE.
    task automatic xfer(input int sel, input bit wr, input bit rd,
                        input logic [18:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rdat,
                        output int lat, output int cyc);
        time t0;
        t0 = $time;
        cur = sel;
        oe_cnt = 0; oe_first = -1; we_cnt = 0; we_first = -1;
        be_seen = 4'hF; lat = -1; rdat = '0;
        drive(sel, wr, rd, a, be, wd);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!m_oe) begin
                if (oe_first < 0) oe_first = k;
                oe_cnt++; be_seen = m_be_n;
            end
            if (!m_we) begin
                if (we_first < 0) we_first = k;
                we_cnt++; be_seen = m_be_n;
            end
            if (!m_wait) begin
                lat = k; rdat = m_rd;
                break;
            end
        end
        chk("wait_timeout", {31'h0, lat < 0}, 32'h0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, a, be, wd);
        cyc = int'(($time - t0) / 10);
    endtask

    task automatic run(input int sel, input bit wr, input bit rd,
                       input logic [18:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
        logic [31:0] rdat, dm, expv;
        logic [3:0]  lm;
        logic [19:0] key;
        int lat, cyc, rw, wp, wh;
        rw = (sel != 0) ? 1 : 2;
        wp = (sel != 0) ? 1 : 2;
        wh = (sel != 0) ? 0 : 1;
        dm = (sel != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        lm = (sel != 0) ? 4'hF : 4'h3;
        key = {sel[0], a};
        xfer(sel, wr, rd, a, be & lm, wd & dm, rdat, lat, cyc);
        if (wr) begin
            chk("wr_lat", 32'(lat), 32'(wp + wh + 1));
            chk("wr_thru", 32'(cyc), 32'(wp + wh + 2));
            chk("we_cycles", 32'(we_cnt), 32'(wp));
            chk("we_first", 32'(we_first), 32'd1);
            chk("wr_no_oe", 32'(oe_cnt), 32'd0);
            chk("wr_be_n", {28'h0, be_seen & lm}, {28'h0, ~be & lm});
            if (rd) chk("rw_keep_rdata", rdat & dm, last_rd[sel]);
            refm[key] = merge(ref_get(key), wd & dm, be & lm);
        end else begin
            expv = ref_get(key);
            chk("rd_lat", 32'(lat), 32'(rw + 1));
            chk("rd_thru", 32'(cyc), 32'(rw + 2));
            chk("oe_cycles", 32'(oe_cnt), 32'(rw));
            chk("oe_first", 32'(oe_first), 32'd1);
            chk("rd_no_we", 32'(we_cnt), 32'd0);
            chk("rd_be_n", {28'h0, be_seen & lm}, {28'h0, ~be & lm});
            chk("rdata", rdat & dm, expv);
            last_rd[sel] = expv;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [18:0] pool [6];
    initial begin
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        last_rd[0] = '0; last_rd[1] = '0;
        memA[19'h12345] = 16'hA5C3; refm[{1'b0, 19'h12345}] = 32'hA5C3;
        memA[19'h00010] = 16'h1234; refm[{1'b0, 19'h00010}] = 32'h1234;
        memB[19'h00100] = 32'hDEADBEEF; refm[{1'b1, 19'h00100}] = 32'hDEADBEEF;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_wait_A", {31'h0, busA.waitrequest}, 32'h1);
        chk("rst_rdata_A", {16'h0, busA.readdata}, 32'h0);
        chk("rst_addr_A", {13'h0, addrA}, 32'h0);
        chk("rst_strobes_A", {29'h0, ceA, oeA, weA}, 32'h7);
        chk("rst_be_n_A", {30'h0, beA}, 32'h3);
        chk("rst_wait_B", {31'h0, busB.waitrequest}, 32'h1);
        chk("rst_strobes_B", {29'h0, ceB, oeB, weB}, 32'h7);
        chk("rst_be_n_B", {28'h0, beB}, 32'hF);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset asserted while WE is low must release pins at once.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 19'h55555, 4'h3, 32'hBEEF);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!weA) break;
        end
        chk("mid_we_low", {31'h0, weA}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", {31'h0, weA}, 32'h1);
        chk("mid_rst_ce_n", {31'h0, ceA}, 32'h1);
        chk("mid_rst_bus_released", {31'h0, dataA == 16'hBEEF}, 32'h0);
        chk("mid_rst_wait", {31'h0, busA.waitrequest}, 32'h1);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'h0, busA.waitrequest}, 32'h1);
        end
        @(posedge clk); #1;

        run(0, 1'b0, 1'b1, 19'h12345, 4'h3, 32'h0);
        run(0, 1'b1, 1'b0, 19'h00010, 4'h2, 32'hBEEF);
        run(0, 1'b0, 1'b1, 19'h00010, 4'h3, 32'h0);
        chk("byte_lane_word", refm[{1'b0, 19'h00010}], 32'hBE34);
        run(0, 1'b0, 1'b1, 19'h7FFFF, 4'h3, 32'h0);
        run(0, 1'b1, 1'b0, 19'h7FFFF, 4'h3, 32'h3C96);
        run(0, 1'b0, 1'b1, 19'h7FFFF, 4'h3, 32'h0);
        run(0, 1'b1, 1'b1, 19'h00020, 4'h3, 32'h1111);
        run(0, 1'b1, 1'b0, 19'h00020, 4'h0, 32'hFFFF);
        run(0, 1'b0, 1'b0 | 1'b1, 19'h00020, 4'h0, 32'h0);
        run(1, 1'b0, 1'b1, 19'h00100, 4'hF, 32'h0);
        run(1, 1'b1, 1'b0, 19'h00100, 4'h5, 32'h11223344);
        run(1, 1'b0, 1'b1, 19'h00100, 4'hF, 32'h0);
        chk("b_lane_word", refm[{1'b1, 19'h00100}], 32'hDE22BE44);

        pool[0] = 19'h00000; pool[1] = 19'h00010; pool[2] = 19'h00020;
        pool[3] = 19'h7FFFF; pool[4] = 19'h12345; pool[5] = 19'h00100;
        for (int n = 0; n < 80; n++) begin
            int sel, op;
            logic [18:0] a;
            sel = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 2));
            a   = ($urandom_range(0, 3) == 0) ? 19'($urandom_range(0, 7))
                                              : pool[$urandom_range(0, 5)];
            run(sel, op != 0, op != 1, a, 4'($urandom_range(0, 15)),
                32'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
